// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 16;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer with async reset to RST_VAL
//  clk, rst : clock, async active-high reset
//  d        : asynchronous input
//  q        : synchronized output
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= {RST_VAL, RST_VAL};
    else     {q, m} <= {m, d};
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver with valid/ready holding register
//  clk, rst          : clock, async active-high reset
//  sin               : serial line, idle high, asynchronous
//  rx_data, rx_valid : held byte and its valid flag
//  rx_ready          : consumer accepts when rx_valid & rx_ready
//  frame_err         : 1-cycle pulse, stop bit sampled low
//  overrun           : 1-cycle pulse, good frame dropped because the holding register was full
//  busy              : receiver not idle
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  logic                 sin_s;
  rx_state_t            state, next;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bits;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick_half, tick_full, stop_done, good, accept, cnt_clr;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sin),
    .q   (sin_s)
  );
  assign tick_half = cnt == HALF_M1;
  assign tick_full = cnt == FULL_M1;
  assign stop_done = state == STOP && tick_full;
  assign good      = stop_done && sin_s;
  assign accept    = rx_valid && rx_ready;
  assign busy      = state != IDLE;
  // START realigns the counter to mid-bit, so every later sample lands at bit centre
  assign cnt_clr   = state == IDLE || state == BREAK || (state == START && tick_half) || tick_full;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = sin_s ? IDLE : START;
      START:   next = !tick_half ? START : sin_s ? IDLE : DATA;
      DATA:    next = (tick_full && bits == LAST_BIT) ? STOP : DATA;
      STOP:    next = !tick_full ? STOP : sin_s ? IDLE : BREAK;
      BREAK:   next = sin_s ? IDLE : BREAK;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bits      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= next;
      cnt       <= cnt_clr ? '0 : cnt + CW'(1);
      bits      <= state == IDLE ? '0 : (state == DATA && tick_full) ? bits + BW'(1) : bits;
      shreg     <= (state == DATA && tick_full) ? {sin_s, shreg[DATA_BITS-1:1]} : shreg;
      frame_err <= stop_done && !sin_s;
      overrun   <= good && rx_valid && !rx_ready;
      if (good && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: random and directed frames checked against a frame-level receiver model
module tb_uart_frame_rx;
  localparam int CPB = 16;
  localparam int LAT = 2 + (8 * CPB + CPB + CPB / 2) + 1;
  typedef struct {
    int         due;
    logic [7:0] b;
    bit         good;
  } frame_t;
  logic       clk = 1'b0, rst = 1'b1, sin = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
  int         errors = 0, checks = 0, cyc = 0;
  int         ferr_seen = 0, ovr_seen = 0, first_valid = -1;
  bit         rand_mode = 1'b0;
  frame_t     pend[$];
  logic [7:0] acc_log[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         e_ferr = 1'b0, e_ovr = 1'b0;
  always #5 clk = ~clk;
  uart_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // Frame-level model: each frame completes LAT edges after its start bit is driven
  initial begin : model
    frame_t f;
    bit hv;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        pend.delete();
      end else begin
        cyc++;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        hv = m_valid && !rx_ready;
        if (m_valid && rx_ready) m_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          f = pend.pop_front();
          if (!f.good) e_ferr = 1'b1;
          else if (hv) e_ovr = 1'b1;
          else begin
            m_data  = f.b;
            m_valid = 1'b1;
          end
        end
      end
    end
  end
  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      check("rx_valid", rx_valid, m_valid);
      check("rx_data", rx_data, m_data);
      check("frame_err", frame_err, e_ferr);
      check("overrun", overrun, e_ovr);
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
      if (rx_valid && first_valid < 0) first_valid = cyc;
      if (rx_valid && rx_ready) acc_log.push_back(rx_data);
    end
  end
  task automatic tick();
    @(negedge clk);
    if (rand_mode) rx_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) tick();
  endtask
  task automatic send(input logic [7:0] b, input bit stop = 1'b1);
    logic [9:0] fr;
    frame_t f;
    fr = {stop, b, 1'b0};
    f.due = cyc + LAT;
    f.b = b;
    f.good = stop;
    pend.push_back(f);
    for (int i = 0; i < 10; i++) begin
      sin = fr[i];
      repeat (CPB) tick();
    end
  endtask
  initial begin : main
    int t0, n;
    logic [7:0] c3, b;
    bit g;
    c3 = 8'hC3;
    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_data", rx_data, 8'h00);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(4);
    t0 = cyc;
    send(8'hA5);
    idle(8);
    check("t1_latency", first_valid - t0, LAT);
    check("t1_beats", acc_log.size(), 1);
    check("t1_byte", acc_log[0], 8'hA5);
    n = acc_log.size();
    send(8'h00);
    send(8'hFF);
    idle(8);
    check("t2_beats", acc_log.size(), n + 2);
    check("t2_first", acc_log[n], 8'h00);
    check("t2_second", acc_log[n+1], 8'hFF);
    n = acc_log.size();
    sin = 1'b0;
    repeat (4) tick();
    sin = 1'b1;
    check("t3_busy_hi", busy, 1'b1);
    repeat (16) tick();
    check("t3_busy_lo", busy, 1'b0);
    check("t3_no_beat", acc_log.size(), n);
    check("t3_no_ferr", ferr_seen, 0);
    send(8'h3C, 1'b0);
    repeat (40 * CPB) tick();
    check("t4_one_ferr", ferr_seen, 1);
    check("t4_break_busy", busy, 1'b1);
    check("t4_no_beat", acc_log.size(), n);
    idle(4 * CPB);
    check("t4_idle", busy, 1'b0);
    send(8'h3C);
    idle(8);
    check("t4_beats", acc_log.size(), n + 1);
    check("t4_byte", acc_log[$], 8'h3C);
    n = acc_log.size();
    rx_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    idle(8);
    check("t5_overrun", ovr_seen, 1);
    check("t5_held", rx_data, 8'h11);
    check("t5_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    idle(4);
    check("t5_beats", acc_log.size(), n + 1);
    check("t5_byte", acc_log[$], 8'h11);
    check("t5_drained", rx_valid, 1'b0);
    sin = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      sin = c3[i];
      repeat (CPB) tick();
    end
    sin = c3[4];
    repeat (CPB / 2) tick();
    check("t6_busy_pre", busy, 1'b1);
    rst = 1'b1;
    sin = 1'b1;
    tick();
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", rx_valid, 1'b0);
    check("t6_rst_data", rx_data, 8'h00);
    check("t6_rst_flags", {frame_err, overrun}, 2'b00);
    repeat (4) tick();
    rst = 1'b0;
    idle(4);
    n = acc_log.size();
    send(8'h5A);
    idle(8);
    check("t6_beats", acc_log.size(), n + 1);
    check("t6_byte", acc_log[$], 8'h5A);
    rand_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      g = $urandom_range(0, 7) != 0;
      send(b, g);
      idle(g ? $urandom_range(0, 40) : $urandom_range(CPB, 40));
    end
    rand_mode = 1'b0;
    rx_ready = 1'b1;
    idle(LAT + 20);
    check("rand_drained", pend.size(), 0);
    check("rand_valid_end", rx_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
